// File: rtl/al_i2c_seq_arbiter_pkg.sv
// Shared types and constants for the auto-load I2C sequence arbiter.
// Holds the FSM state encoding and the select/retry field widths.
package al_i2c_pkg;

  localparam int SEL_W    = 3;
  localparam int RETRY_W  = 3;
  localparam int MAX_NREQ = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_ABORT   = 3'd4,
    S_DONE_ST = 3'd5,
    S_FAIL    = 3'd6
  } arb_state_e;

endpackage

// File: rtl/al_i2c_seq_arbiter_if.sv
// Requester/engine side bundle of the sequence arbiter.
// master = arbiter, slave = requesters plus sequence engine.
interface al_i2c_seq_arbiter_if #(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]                 REQ;
  logic [NREQ-1:0]                 GNT;
  logic [al_i2c_pkg::SEL_W-1:0]    SEL;
  logic                            AL_DATA_RDY;
  logic                            AL_ABORT;
  logic                            SEQ_DONE;
  logic [NREQ-1:0]                 DONE;
  logic [NREQ-1:0]                 ERR;
  logic                            BUSY;
  logic [al_i2c_pkg::RETRY_W-1:0]  RETRY_CNT;

  modport master (
    input  REQ, SEQ_DONE,
    output GNT, SEL, AL_DATA_RDY, AL_ABORT, DONE, ERR, BUSY, RETRY_CNT
  );

  modport slave (
    output REQ, SEQ_DONE,
    input  GNT, SEL, AL_DATA_RDY, AL_ABORT, DONE, ERR, BUSY, RETRY_CNT
  );

endinterface

// File: rtl/al_i2c_seq_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// the pointer, wrapping modulo NREQ.
module rr_pick
  import al_i2c_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  localparam int SUM_W = SEL_W + 1;

  logic [MAX_NREQ-1:0] req_pad;
  logic [SUM_W-1:0]    sum  [NREQ];
  logic [SEL_W-1:0]    cand [NREQ];

  assign req_pad = MAX_NREQ'(req);

  // cand[k] is the requester at priority rank k; wrap by one conditional subtract
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, ptr} + SUM_W'(gi + 1);
      assign cand[gi] = (sum[gi] >= SUM_W'(NREQ)) ? SEL_W'(sum[gi] - SUM_W'(NREQ))
                                                  : sum[gi][SEL_W-1:0];
    end
  endgenerate

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_pad[cand[k]]) begin
        idx   = cand[k];
        valid = 1'b1;
      end
    end
  end

  assign onehot = valid ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/al_i2c_seq_arbiter.sv
// Round-robin owner of the auto-load I2C sequence engine with a per-run
// watchdog, bounded relaunch and per-requester DONE/ERR pulses.
module al_i2c_seq_arbiter
  import al_i2c_pkg::*;
#(
  parameter int          NREQ       = 3,
  parameter int          TMO_W      = 16,
  parameter int unsigned TMO_CYCLES = 32'h0000_FFFF,
  parameter int          MAX_RETRY  = 2
) (
  input logic                   CLK,
  input logic                   RST_N,
  al_i2c_seq_arbiter_if.master  bus
);

  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TMO_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  arb_state_e         state_reg, state_next;
  logic [TMO_W-1:0]   wdog_reg;
  logic [SEL_W-1:0]   ptr_reg, sel_reg, pick_idx;
  logic [NREQ-1:0]    gnt_reg, done_reg, err_reg, pick_onehot;
  logic [RETRY_W-1:0] retry_reg;
  logic               rdy_reg, abort_reg, busy_reg;
  logic               pick_valid, timeout;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.REQ),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign timeout = (wdog_reg == TMO_LAST);

  // Completion is tested before the watchdog so a coincident SEQ_DONE wins.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (pick_valid) state_next = S_GRANT;
      S_GRANT:   state_next = S_LAUNCH;
      S_LAUNCH:  state_next = S_WAIT;
      S_WAIT: begin
        if (bus.SEQ_DONE)    state_next = S_DONE_ST;
        else if (timeout)    state_next = (retry_reg < RETRY_LIM) ? S_ABORT : S_FAIL;
      end
      S_ABORT:   state_next = S_LAUNCH;
      S_DONE_ST: state_next = S_IDLE;
      S_FAIL:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
      wdog_reg  <= '0;
      ptr_reg   <= SEL_W'(NREQ - 1);
      sel_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      err_reg   <= '0;
      retry_reg <= '0;
      rdy_reg   <= 1'b0;
      abort_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
      rdy_reg   <= (state_next == S_LAUNCH);
      abort_reg <= (state_next == S_ABORT);
      done_reg  <= (state_next == S_DONE_ST) ? gnt_reg : '0;
      err_reg   <= (state_next == S_FAIL)    ? gnt_reg : '0;
      wdog_reg  <= (state_reg == S_WAIT && state_next == S_WAIT) ? wdog_reg + 1'b1 : '0;

      // Winner is frozen here; later REQ activity cannot disturb the service.
      if (state_reg == S_IDLE && state_next == S_GRANT) begin
        gnt_reg   <= pick_onehot;
        sel_reg   <= pick_idx;
        ptr_reg   <= pick_idx;
        retry_reg <= '0;
      end else if (state_next == S_DONE_ST || state_next == S_FAIL || state_next == S_IDLE) begin
        gnt_reg   <= '0;
        sel_reg   <= '0;
        retry_reg <= '0;
      end else if (state_next == S_ABORT) begin
        retry_reg <= retry_reg + 1'b1;
      end
    end
  end

  assign bus.GNT         = gnt_reg;
  assign bus.SEL         = sel_reg;
  assign bus.AL_DATA_RDY = rdy_reg;
  assign bus.AL_ABORT    = abort_reg;
  assign bus.DONE        = done_reg;
  assign bus.ERR         = err_reg;
  assign bus.BUSY        = busy_reg;
  assign bus.RETRY_CNT   = retry_reg;

endmodule

// File: tb/tb_al_i2c_seq_arbiter.sv
// Randomized bench for al_i2c_seq_arbiter: each service is predicted as a
// cycle timeline from the arbitration/timeout rules and compared every cycle.
module tb_al_i2c_seq_arbiter;

  localparam int NREQ   = 3;
  localparam int TMO    = 16;
  localparam int MAXR   = 2;
  localparam int TL_MAX = 128;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  al_i2c_seq_arbiter_if #(.NREQ(NREQ)) bus ();

  al_i2c_seq_arbiter #(
    .NREQ       (NREQ),
    .TMO_W      (16),
    .TMO_CYCLES (TMO),
    .MAX_RETRY  (MAXR)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = NREQ - 1;
  int svc_n    = 0;

  logic [17:0] exp_tl [TL_MAX];
  logic        sd_tl  [TL_MAX];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // status word: {GNT, SEL, AL_DATA_RDY, AL_ABORT, DONE, ERR, BUSY, RETRY_CNT}
  function automatic logic [17:0] st(logic [2:0] g, logic [2:0] s, logic r, logic a,
                                     logic [2:0] d, logic [2:0] e, logic b, logic [2:0] rc);
    return {g, s, r, a, d, e, b, rc};
  endfunction

  function automatic logic [17:0] observe();
    return {bus.GNT, bus.SEL, bus.AL_DATA_RDY, bus.AL_ABORT,
            bus.DONE, bus.ERR, bus.BUSY, bus.RETRY_CNT};
  endfunction

  function automatic int rr_model(logic [NREQ-1:0] m, int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.REQ      = '0;
      bus.SEQ_DONE = 1'($urandom % 2);
      @(negedge CLK);
      check_eq("idle", 32'(observe()), 32'd0);
      @(posedge CLK);
      #1;
    end
    bus.SEQ_DONE = 1'b0;
  endtask

  // Caller is #1 after a rising edge with the DUT idle. n_tmo = attempts that
  // time out before the engine answers after d WAIT cycles.
  task automatic run_service(input logic [NREQ-1:0] mask, input int n_tmo, input int d,
                             input bit junk, input int stop_at, output int sel_seen);
    int          w, L, E, last;
    logic [2:0]  oh, ws;
    logic [17:0] got;
    w     = rr_model(mask, ptr_m);
    ptr_m = w;
    oh    = 3'(NREQ'(1) << w);
    ws    = 3'(w);
    for (int c = 0; c < TL_MAX; c++) begin
      exp_tl[c] = '0;
      sd_tl[c]  = 1'b0;
    end
    sd_tl[0]  = 1'($urandom % 2);
    sd_tl[1]  = 1'($urandom % 2);
    exp_tl[1] = st(oh, ws, 0, 0, 0, 0, 1, 0);
    L = 2;
    E = 0;
    for (int a = 0; a <= MAXR; a++) begin
      exp_tl[L] = st(oh, ws, 1, 0, 0, 0, 1, 3'(a));
      sd_tl[L]  = 1'($urandom % 2);
      if (a < n_tmo) begin
        for (int k = 1; k <= TMO; k++) exp_tl[L+k] = st(oh, ws, 0, 0, 0, 0, 1, 3'(a));
        if (a < MAXR) begin
          exp_tl[L+TMO+1] = st(oh, ws, 0, 1, 0, 0, 1, 3'(a + 1));
          sd_tl[L+TMO+1]  = 1'($urandom % 2);
          L = L + TMO + 2;
        end else begin
          E = L + TMO + 1;
          exp_tl[E] = st(0, 0, 0, 0, 0, oh, 1, 0);
        end
      end else begin
        for (int k = 1; k <= d + 1; k++) exp_tl[L+k] = st(oh, ws, 0, 0, 0, 0, 1, 3'(a));
        sd_tl[L+1+d] = 1'b1;
        E = L + d + 2;
        exp_tl[E] = st(0, 0, 0, 0, oh, 0, 1, 0);
      end
      if (E != 0) break;
    end
    sd_tl[E] = 1'($urandom % 2);
    last     = (stop_at >= 0 && stop_at < E) ? stop_at : E;
    sel_seen = -1;
    for (int c = 0; c <= last; c++) begin
      bus.REQ      = (c == 0 || !junk) ? mask : NREQ'($urandom);
      bus.SEQ_DONE = sd_tl[c];
      @(negedge CLK);
      got = observe();
      if (c == 1) sel_seen = int'(bus.SEL);
      check_eq($sformatf("svc%0d_c%0d", svc_n, c), 32'(got), 32'(exp_tl[c]));
      @(posedge CLK);
      #1;
    end
    bus.REQ      = '0;
    bus.SEQ_DONE = 1'b0;
    $display("svc %0d mask=%b winner=%0d timeouts=%0d delay=%0d cycles=%0d",
             svc_n, mask, w, n_tmo, d, last + 1);
    svc_n++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s;
    int fair_order [4] = '{0, 1, 2, 0};
    bus.REQ      = '0;
    bus.SEQ_DONE = 1'b0;
    RST_N        = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset", 32'(observe()), 32'd0);
    RST_N = 1'b1;

    // single request shortly after reset
    idle_cycles(8);
    run_service(3'b001, 0, 10, 0, -1, s);
    check_eq("single_sel", 32'(s), 32'd0);

    // one timeout then completion; leaves the pointer at requester 2
    run_service(3'b100, 1, $urandom_range(0, TMO - 1), 1, -1, s);
    check_eq("retry_sel", 32'(s), 32'd2);

    // all requesting, held back-to-back
    for (int k = 0; k < 4; k++) begin
      run_service(3'b111, 0, $urandom_range(0, TMO - 1), 0, -1, s);
      check_eq($sformatf("fair%0d", k), 32'(s), 32'(fair_order[k]));
    end

    // retries exhausted
    idle_cycles(1);
    run_service(3'b010, MAXR + 1, 0, 1, -1, s);

    // completion coincident with the watchdog terminal count
    run_service(3'($urandom_range(1, 7)), 0, TMO - 1, 1, -1, s);
    run_service(3'($urandom_range(1, 7)), MAXR, TMO - 1, 1, -1, s);

    for (int k = 0; k < 16; k++) begin
      idle_cycles($urandom_range(0, 2));
      run_service(3'($urandom_range(1, 7)), $urandom_range(0, MAXR + 1),
                  $urandom_range(0, TMO - 1), 1, -1, s);
    end

    // asynchronous reset in the middle of WAIT with requests held
    run_service(3'b010, MAXR + 1, 0, 0, 6, s);
    bus.REQ = 3'b111;
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("rst_async", 32'(observe()), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("rst_hold", 32'(observe()), 32'd0);
    RST_N = 1'b1;
    ptr_m = NREQ - 1;
    run_service(3'b111, 0, 5, 0, -1, s);
    check_eq("rst_first", 32'(s), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
